laser_rx_bit_sampler: RTL and testbench

Receive-side counterpart of the laser transmit clocking. The transmitter shifts bits at a divided rate. This block recovers that timing from the photodiode line using only CLOCK_50.
- Synchronises rx_in and detects its edges.
- Re-phases an 8-bit bit-period counter on each valid edge.
- Emits one mid-bit sample strobe per bit period.
- Sits between the photodiode input pin and the receive deserialiser/framer.

---
 rtl/laser_rx_bit_sampler_pkg.sv | 20 ++
 rtl/laser_rx_bit_sampler_if.sv | 24 ++
 rtl/laser_rx_bit_sampler_sync_edge_detect.sv | 33 +++
 rtl/laser_rx_bit_sampler.sv | 129 ++++++++++++
 tb/tb_laser_rx_bit_sampler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_rx_bit_sampler_pkg.sv
// Shared types and constants for the laser receive bit sampler.
package laser_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    TRACK
  } rx_state_t;

  // Shortest bit period the counter can track; smaller programmed values clamp here.
  localparam logic [7:0] MIN_BIT_PERIOD    = 8'd4;
  localparam int         DEF_MAX_IDLE_BITS = 16;
  localparam int         DEF_SYNC_STAGES   = 2;

  // Effective bit period: programmed value clamped to the minimum.
  function automatic logic [7:0] eff_period(input logic [7:0] bp);
    return (bp < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : bp;
  endfunction

endpackage

// File: rtl/laser_rx_bit_sampler_if.sv
// Control, serial line and recovered-bit signals of the bit sampler.
interface laser_rx_bit_sampler_if;

  logic       en;
  logic [7:0] bit_period;
  logic       rx_in;
  logic       sample_valid;
  logic       sample_bit;
  logic       locked;
  logic       glitch;

  // Driver side: enable, period programming and the photodiode line.
  modport master (
    output en, bit_period, rx_in,
    input  sample_valid, sample_bit, locked, glitch
  );

  // Sampler side.
  modport slave (
    input  en, bit_period, rx_in,
    output sample_valid, sample_bit, locked, glitch
  );

endinterface

// File: rtl/laser_rx_bit_sampler_sync_edge_detect.sv
// Multi-flop synchroniser for the asynchronous rx line plus transition detect.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic q,
  output logic rx_edge
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev;

  // Shift the line through the synchroniser; prev is the last stage one cycle late.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_r <= '0;
      prev   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      // prev reloads from q every cycle, including under clear.
      prev   <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

  // Masked while clear is high so a stale prev cannot report a transition.
  assign rx_edge = (q != prev) && !clear;

endmodule

// File: rtl/laser_rx_bit_sampler.sv
// Recovers bit timing from the photodiode line: re-phases a bit-period
// counter on each accepted edge and strobes one mid-bit sample per period.
module laser_rx_bit_sampler
  import laser_rx_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int MAX_IDLE_BITS = DEF_MAX_IDLE_BITS
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  laser_rx_bit_sampler_if.slave bus
);

  localparam logic [7:0] MAX_IDLE = 8'(MAX_IDLE_BITS);

  rx_state_t  state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] idle_bits, idle_n;
  logic       sv_r, sv_n;
  logic       sb_r, sb_n;
  logic       lk_r, lk_n;
  logic       gl_r, gl_n;

  logic       hold;
  logic       clear;
  logic       sync_q;
  logic       rx_edge;
  logic [7:0] p_eff, h_pt, q_win;

  // en low is treated exactly like reset.
  assign hold  = reset || !bus.en;
  assign clear = (state == IDLE);

  assign p_eff = eff_period(bus.bit_period);
  assign h_pt  = p_eff >> 1;
  assign q_win = p_eff >> 2;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLOCK_50(CLOCK_50),
    .reset   (hold),
    .clear   (clear),
    .d       (bus.rx_in),
    .q       (sync_q),
    .rx_edge (rx_edge)
  );

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (hold) begin
      state     <= IDLE;
      cnt       <= '0;
      idle_bits <= '0;
      sv_r      <= 1'b0;
      sb_r      <= 1'b0;
      lk_r      <= 1'b0;
      gl_r      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idle_bits <= idle_n;
      sv_r      <= sv_n;
      sb_r      <= sb_n;
      lk_r      <= lk_n;
      gl_r      <= gl_n;
    end
  end

  // Next state: acquire on first edge, then track with glitch rejection,
  // edge re-phasing, mid-bit sampling and free-running over edge-free bits.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idle_n  = idle_bits;
    sv_n    = 1'b0;
    sb_n    = sb_r;
    lk_n    = lk_r;
    gl_n    = 1'b0;
    case (state)
      IDLE: begin
        state_n = HUNT;
        cnt_n   = '0;
        idle_n  = '0;
        lk_n    = 1'b0;
      end
      HUNT: begin
        if (rx_edge) begin
          state_n = TRACK;
          cnt_n   = '0;
          idle_n  = '0;
          lk_n    = 1'b1;
        end
      end
      TRACK: begin
        if (rx_edge && cnt >= q_win) begin
          // Accepted edge re-phases the counter; it also pre-empts a
          // coincident mid-bit sample.
          cnt_n  = '0;
          idle_n = '0;
        end else begin
          // An edge this close to the last one is noise; count on regardless.
          gl_n = rx_edge;
          if (cnt == h_pt) begin
            sv_n  = 1'b1;
            sb_n  = sync_q;
            cnt_n = cnt + 8'd1;
          end else if (cnt >= p_eff - 8'd1) begin
            cnt_n  = '0;
            idle_n = idle_bits + 8'd1;
            if (idle_n == MAX_IDLE) begin
              state_n = HUNT;
              lk_n    = 1'b0;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sample_valid = sv_r;
  assign bus.sample_bit   = sb_r;
  assign bus.locked       = lk_r;
  assign bus.glitch       = gl_r;

endmodule

// File: tb/tb_laser_rx_bit_sampler.sv
// Directed bench for the laser bit sampler. Stimulus pushes expected
// strobe / glitch / lock-change events (cycle + value) into queues; a
// monitor on the falling edge matches every DUT event against them.
module tb_laser_rx_bit_sampler;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic exp_lock = 1'b0;
  logic lk_prev = 1'b0;

  ev_t sv_q[$];
  ev_t gl_q[$];
  ev_t lk_q[$];
  ev_t e;

  laser_rx_bit_sampler_if bus ();

  laser_rx_bit_sampler #(
    .SYNC_STAGES  (2),
    .MAX_IDLE_BITS(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic void exp_sv(input int c, input logic b);
    sv_q.push_back(ev_t'{cyc: c, val: b});
  endfunction
  function automatic void exp_gl(input int c);
    gl_q.push_back(ev_t'{cyc: c, val: 1'b1});
  endfunction
  function automatic void exp_lk(input int c, input logic v);
    lk_q.push_back(ev_t'{cyc: c, val: v});
  endfunction

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge CLOCK_50) begin
    while (sv_q.size() != 0 && sv_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL strobe_missed: required strobe at cycle %0d did not occur", sv_q[0].cyc);
      void'(sv_q.pop_front());
    end
    while (gl_q.size() != 0 && gl_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL glitch_missed: required glitch at cycle %0d did not occur", gl_q[0].cyc);
      void'(gl_q.pop_front());
    end
    while (lk_q.size() != 0 && lk_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL lock_missed: no change seen, required locked=%0b at cycle %0d",
               lk_q[0].val, lk_q[0].cyc);
      void'(lk_q.pop_front());
    end
    if (bus.sample_valid === 1'b1) begin
      checks++;
      if (sv_q.size() == 0 || sv_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL strobe_unexpected: got strobe at cycle %0d, required none", cyc);
      end else begin
        e = sv_q.pop_front();
        if (bus.sample_bit !== e.val) begin
          errors++;
          $display("FAIL sample_bit: cycle %0d got %0b required %0b", cyc, bus.sample_bit, e.val);
        end
      end
    end
    if (bus.glitch === 1'b1) begin
      checks++;
      if (gl_q.size() == 0 || gl_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL glitch_unexpected: got glitch at cycle %0d, required none", cyc);
      end else begin
        void'(gl_q.pop_front());
      end
    end
    if (bus.locked !== lk_prev) begin
      checks++;
      if (lk_q.size() == 0 || lk_q[0].cyc != cyc || lk_q[0].val !== bus.locked) begin
        errors++;
        $display("FAIL lock_change: got locked=%0b at cycle %0d, not an expected change",
                 bus.locked, cyc);
      end else begin
        void'(lk_q.pop_front());
      end
      lk_prev = bus.locked;
    end
  end

  // Wait (from a falling edge) until a change made now lands before posedge k.
  task automatic go(input int k);
    while (cyc < k - 1) @(negedge CLOCK_50);
  endtask

  task automatic send(input int k, input logic b);
    go(k);
    bus.rx_in = b;
  endtask

  // Drop en (clearing the block), reprogram the period and re-enable.
  task automatic restart(input logic [7:0] bp);
    bus.en    = 1'b0;
    bus.rx_in = 1'b0;
    if (exp_lock) begin
      exp_lk(cyc + 1, 1'b0);
      exp_lock = 1'b0;
    end
    repeat (3) @(negedge CLOCK_50);
    bus.bit_period = bp;
    bus.en         = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    int          k, k0, s, last_s;
    logic        b, prev;
    logic [4:0]  t2;
    logic [63:0] data;

    t2   = 5'b10110;
    data = 64'h6666_5A5A_9999_A5A5;

    // Reset wins over en; rx toggling under reset must not reach the outputs.
    reset          = 1'b1;
    bus.en         = 1'b1;
    bus.bit_period = 8'd10;
    bus.rx_in      = 1'b0;
    @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = ~bus.rx_in;
      @(negedge CLOCK_50);
      checks++;
      if ({bus.sample_valid, bus.sample_bit, bus.locked, bus.glitch} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: got %b required 0000",
                 {bus.sample_valid, bus.sample_bit, bus.locked, bus.glitch});
      end
    end
    bus.rx_in = 1'b0;
    reset     = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL hunt_no_lock: got locked=%0b required 0", bus.locked);
    end

    // Lock and sample timing, P=10, 1,0,1,1,0 at 10 cycles/bit.
    restart(8'd10);
    k = cyc + 3;
    exp_lk(k + 2, 1'b1);
    exp_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = t2[4-i];
      exp_sv(k + 8 + 10 * i, b);
      send(k + 10 * i, b);
    end
    go(k + 51);

    // Free-run then loss of lock after 4 edge-free wraps.
    restart(8'd10);
    k = cyc + 3;
    exp_lk(k + 2, 1'b1);
    for (int i = 0; i < 4; i++) exp_sv(k + 8 + 10 * i, 1'b1);
    exp_lk(k + 42, 1'b0);
    send(k, 1'b1);
    go(k + 70);

    // Glitch rejection, P=20: 2-cycle pulse 2 cycles after the locking edge.
    restart(8'd20);
    k = cyc + 3;
    exp_lk(k + 2, 1'b1);
    exp_lock = 1'b1;
    exp_gl(k + 4);
    exp_gl(k + 6);
    exp_sv(k + 13, 1'b1);
    exp_sv(k + 33, 1'b0);
    send(k, 1'b1);
    send(k + 2, 1'b0);
    send(k + 4, 1'b1);
    send(k + 20, 1'b0);
    go(k + 36);

    // Edge lands exactly on the mid-bit count, P=8.
    restart(8'd8);
    k = cyc + 3;
    exp_lk(k + 2, 1'b1);
    exp_lock = 1'b1;
    exp_sv(k + 12, 1'b0);
    send(k, 1'b1);
    send(k + 5, 1'b0);
    go(k + 15);

    // Period clamp: bit_period=2 must behave as P=4 (H=2).
    restart(8'd2);
    k = cyc + 3;
    exp_lk(k + 2, 1'b1);
    exp_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = (i % 2 == 0);
      exp_sv(k + 5 + 4 * i, b);
      send(k + 4 * i, b);
    end
    go(k + 19);

    // Drift: P=10, transmitter 10% fast (9 cycles/bit), preamble 1 + 64 data bits.
    restart(8'd10);
    k0 = cyc + 3;
    exp_lk(k0 + 2, 1'b1);
    exp_lock = 1'b1;
    prev   = 1'b0;
    last_s = 0;
    k      = k0;
    for (int i = 0; i < 65; i++) begin
      b = (i == 0) ? 1'b1 : data[64-i];
      k = k0 + 9 * i;
      s = (b != prev) ? k + 8 : last_s + 10;
      exp_sv(s, b);
      send(k, b);
      prev   = b;
      last_s = s;
    end
    go(k + 11);
    restart(8'd10);
    repeat (5) @(negedge CLOCK_50);

    checks++;
    if (sv_q.size() != 0) begin
      errors++;
      $display("FAIL strobe_queue: got %0d pending, required 0", sv_q.size());
    end
    checks++;
    if (gl_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_queue: got %0d pending, required 0", gl_q.size());
    end
    checks++;
    if (lk_q.size() != 0) begin
      errors++;
      $display("FAIL lock_queue: got %0d pending, required 0", lk_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
